// File: rtl/ws2812_pkg.sv
// Shared types and defaults for the WS2812 frame scheduler.
// Contents: FSM state enum, 24-bit GRB colour type, default inter-frame gap,
// and a per-channel brightness scaling helper.
package ws2812_pkg;

    typedef enum logic [2:0] {
        IDLE,
        OWN_A,
        OWN_B,
        KICK,
        SEND,
        GAP
    } state_t;

    typedef logic [23:0] color_t;

    // 300 us of idle line at 100 MHz latches the LED chain.
    localparam int unsigned DEFAULT_MIN_GAP = 30000;

    // (ch * level) >> 8 for one 8-bit colour channel.
    function automatic logic [7:0] scale_channel(input logic [7:0] ch, input logic [7:0] level);
        logic [15:0] prod;
        prod = 16'(ch) * 16'(level);
        return prod[15:8];
    endfunction

endpackage

// File: rtl/ws2812_rr_arb.sv
// Two-way round-robin choice between requesters A and B.
// Ports:
//   clk100, reset : clock, synchronous active-high reset
//   a_req, b_req  : pending requests
//   take          : high when the scheduler is free to start a new owner
//   pick_b_c      : combinational choice, 1 = grant B, 0 = grant A
module ws2812_rr_arb (
    input  logic clk100,
    input  logic reset,
    input  logic a_req,
    input  logic b_req,
    input  logic take,
    output logic pick_b_c
);

    // 1 = B has priority on a tie (A was served last); reset favours A.
    logic prio_b;

    assign pick_b_c = b_req && (!a_req || prio_b);

    always_ff @(posedge clk100) begin
        if (reset) begin
            prio_b <= 1'b0;
        end else if (take && (a_req || b_req)) begin
            prio_b <= !pick_b_c;
        end
    end

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Arbitrates two pixel writers into a WS2812 colour RAM, then kicks the LED
// driver to send the frame and enforces the latch gap before the next owner.
// Optional macro WS2812_BRIGHTNESS_EN adds an 8-bit brightness input that
// scales every colour channel on its way into the RAM.
// Ports:
//   clk100, reset                            : clock, synchronous active-high reset
//   a_req/a_last/a_addr/a_data, a_gnt        : requester A pixel stream
//   b_req/b_last/b_addr/b_data, b_gnt        : requester B pixel stream
//   ram_we, ram_wraddress, ram_data          : colour-RAM write port
//   update_request, update_done              : frame-send handshake with driver
//   busy                                     : scheduler not in IDLE
//   drop_err                                 : sticky, an out-of-range beat was seen
//   brightness (WS2812_BRIGHTNESS_EN only)   : channel scale factor
module ws2812_frame_scheduler
    import ws2812_pkg::*;
#(
    parameter int unsigned LED_NUM  = 16,
    parameter int unsigned ADDR_BIT = $clog2(LED_NUM) + 1,
    parameter int unsigned MIN_GAP  = DEFAULT_MIN_GAP
) (
    input  logic                clk100,
    input  logic                reset,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]          brightness,
`endif
    input  logic                a_req,
    input  logic                a_last,
    input  logic [ADDR_BIT-1:0] a_addr,
    input  logic [23:0]         a_data,
    output logic                a_gnt,
    input  logic                b_req,
    input  logic                b_last,
    input  logic [ADDR_BIT-1:0] b_addr,
    input  logic [23:0]         b_data,
    output logic                b_gnt,
    output logic                ram_we,
    output logic [ADDR_BIT-1:0] ram_wraddress,
    output logic [23:0]         ram_data,
    output logic                update_request,
    input  logic                update_done,
    output logic                busy,
    output logic                drop_err
);

    localparam int unsigned GAP_W = $clog2(MIN_GAP + 1);

    state_t              state;
    logic [GAP_W-1:0]    gap_cnt;
    logic                pick_b_c;
    logic                accept_c;
    logic                beat_last_c;
    logic [ADDR_BIT-1:0] beat_addr_c;
    color_t              beat_data_c;
    color_t              wr_data_c;
    logic                in_range_c;

    ws2812_rr_arb u_arb (
        .clk100   (clk100),
        .reset    (reset),
        .a_req    (a_req),
        .b_req    (b_req),
        .take     (state == IDLE),
        .pick_b_c (pick_b_c)
    );

    // Select the beat of the current owner; a beat only counts while granted.
    always_comb begin
        accept_c    = 1'b0;
        beat_last_c = 1'b0;
        beat_addr_c = '0;
        beat_data_c = '0;
        if (state == OWN_A) begin
            accept_c    = a_req && a_gnt;
            beat_last_c = a_last;
            beat_addr_c = a_addr;
            beat_data_c = a_data;
        end else if (state == OWN_B) begin
            accept_c    = b_req && b_gnt;
            beat_last_c = b_last;
            beat_addr_c = b_addr;
            beat_data_c = b_data;
        end
    end

    assign in_range_c = 32'(beat_addr_c) < LED_NUM;

`ifdef WS2812_BRIGHTNESS_EN
    assign wr_data_c = {scale_channel(beat_data_c[23:16], brightness),
                        scale_channel(beat_data_c[15:8],  brightness),
                        scale_channel(beat_data_c[7:0],   brightness)};
`else
    assign wr_data_c = beat_data_c;
`endif

    // Scheduler FSM; all outputs are registered here.
    always_ff @(posedge clk100) begin
        if (reset) begin
            state          <= IDLE;
            a_gnt          <= 1'b0;
            b_gnt          <= 1'b0;
            ram_we         <= 1'b0;
            ram_wraddress  <= '0;
            ram_data       <= '0;
            update_request <= 1'b0;
            busy           <= 1'b0;
            drop_err       <= 1'b0;
            gap_cnt        <= '0;
        end else begin
            ram_we <= 1'b0;
            if (accept_c) begin
                if (in_range_c) begin
                    ram_we        <= 1'b1;
                    ram_wraddress <= beat_addr_c;
                    ram_data      <= wr_data_c;
                end else begin
                    drop_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (a_req || b_req) begin
                        state <= pick_b_c ? OWN_B : OWN_A;
                        busy  <= 1'b1;
                    end
                end
                // Grant rises one cycle into ownership and drops with the last beat.
                OWN_A: begin
                    if (accept_c && beat_last_c) begin
                        state <= KICK;
                        a_gnt <= 1'b0;
                    end else begin
                        a_gnt <= 1'b1;
                    end
                end
                OWN_B: begin
                    if (accept_c && beat_last_c) begin
                        state <= KICK;
                        b_gnt <= 1'b0;
                    end else begin
                        b_gnt <= 1'b1;
                    end
                end
                // One cycle for the final RAM write to land before the driver starts.
                KICK: begin
                    state          <= SEND;
                    update_request <= 1'b1;
                end
                SEND: begin
                    if (update_done) begin
                        state          <= GAP;
                        update_request <= 1'b0;
                        gap_cnt        <= '0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(MIN_GAP - 1)) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state          <= IDLE;
                    a_gnt          <= 1'b0;
                    b_gnt          <= 1'b0;
                    update_request <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Self-checking bench for ws2812_frame_scheduler (LED_NUM=16, MIN_GAP=8).
module tb_ws2812_frame_scheduler;

    localparam int unsigned LED_NUM  = 16;
    localparam int unsigned ADDR_BIT = 5;
    localparam int unsigned MIN_GAP  = 8;

    logic                clk100 = 1'b0;
    logic                reset;
    logic                a_req, a_last, b_req, b_last;
    logic [ADDR_BIT-1:0] a_addr, b_addr;
    logic [23:0]         a_data, b_data;
    logic                a_gnt, b_gnt, ram_we, update_request, update_done, busy, drop_err;
    logic [ADDR_BIT-1:0] ram_wraddress;
    logic [23:0]         ram_data;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0]          brightness;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk100 = ~clk100;

    ws2812_frame_scheduler #(
        .LED_NUM  (LED_NUM),
        .ADDR_BIT (ADDR_BIT),
        .MIN_GAP  (MIN_GAP)
    ) dut (
        .clk100         (clk100),
        .reset          (reset),
`ifdef WS2812_BRIGHTNESS_EN
        .brightness     (brightness),
`endif
        .a_req          (a_req),
        .a_last         (a_last),
        .a_addr         (a_addr),
        .a_data         (a_data),
        .a_gnt          (a_gnt),
        .b_req          (b_req),
        .b_last         (b_last),
        .b_addr         (b_addr),
        .b_data         (b_data),
        .b_gnt          (b_gnt),
        .ram_we         (ram_we),
        .ram_wraddress  (ram_wraddress),
        .ram_data       (ram_data),
        .update_request (update_request),
        .update_done    (update_done),
        .busy           (busy),
        .drop_err       (drop_err)
    );

    typedef struct {
        logic                a_req;
        logic                a_last;
        logic [ADDR_BIT-1:0] a_addr;
        logic [23:0]         a_data;
        logic                update_done;
        logic                x_a_gnt;
        logic                x_ram_we;
        logic [ADDR_BIT-1:0] x_addr;
        logic [23:0]         x_data;
        logic                x_ureq;
        logic                x_busy;
        logic                x_drop;
    } vec_t;

    vec_t vecs[20];

    // Expected RAM contents for a given input colour.
    function automatic logic [23:0] exp_color(input logic [23:0] d);
`ifdef WS2812_BRIGHTNESS_EN
        logic [15:0] p2, p1, p0;
        p2 = 16'(d[23:16]) * 16'(brightness);
        p1 = 16'(d[15:8])  * 16'(brightness);
        p0 = 16'(d[7:0])   * 16'(brightness);
        return {p2[15:8], p1[15:8], p0[15:8]};
`else
        return d;
`endif
    endfunction

    task automatic tick;
        @(posedge clk100);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs;
        a_req = 1'b0; a_last = 1'b0; a_addr = '0; a_data = '0;
        b_req = 1'b0; b_last = 1'b0; b_addr = '0; b_data = '0;
        update_done = 1'b0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Bounded wait for a grant; an expired bound counts as a failure.
    task automatic wait_gnt(input bit want_b);
        int n;
        n = 0;
        while (((want_b ? b_gnt : a_gnt) !== 1'b1) && n < 20) begin
            tick();
            n++;
        end
        chk(want_b ? "wait_b_gnt" : "wait_a_gnt", 32'(n < 20), 32'(1));
    endtask

    // Bounded wait for the GAP to finish; returns observed busy cycles.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        int gap_cycles;
        int we_count;
`ifdef WS2812_BRIGHTNESS_EN
        brightness = 8'hFF;
`endif
        // inputs: a_req a_last a_addr a_data update_done | expect: a_gnt ram_we addr data ureq busy drop
        vecs[0]  = '{1, 0, 0,  24'h000000, 1, 0, 0, 0, 24'h000000, 0, 1, 0};
        vecs[1]  = '{1, 0, 0,  24'h111111, 0, 1, 0, 0, 24'h000000, 0, 1, 0};
        vecs[2]  = '{1, 0, 3,  24'hABCDEF, 0, 1, 1, 3, 24'hABCDEF, 0, 1, 0};
        vecs[3]  = '{1, 1, 5,  24'h123456, 0, 0, 1, 5, 24'h123456, 0, 1, 0};
        vecs[4]  = '{0, 0, 0,  24'h000000, 0, 0, 0, 5, 24'h123456, 1, 1, 0};
        vecs[5]  = '{1, 0, 0,  24'h000000, 0, 0, 0, 5, 24'h123456, 1, 1, 0};
        vecs[6]  = '{1, 0, 0,  24'h000000, 1, 0, 0, 5, 24'h123456, 0, 1, 0};
        for (int i = 7; i < 14; i++)
            vecs[i] = '{1, 0, 0, 24'h000000, 1'(i % 2), 0, 0, 5, 24'h123456, 0, 1, 0};
        vecs[14] = '{1, 0, 0,  24'h000000, 0, 0, 0, 5, 24'h123456, 0, 0, 0};
        vecs[15] = '{1, 0, 0,  24'h000000, 0, 0, 0, 5, 24'h123456, 0, 1, 0};
        vecs[16] = '{1, 0, 0,  24'h000000, 0, 1, 0, 5, 24'h123456, 0, 1, 0};
        vecs[17] = '{1, 1, 20, 24'hFFFFFF, 0, 0, 0, 5, 24'h123456, 0, 1, 1};
        vecs[18] = '{0, 0, 0,  24'h000000, 0, 0, 0, 5, 24'h123456, 1, 1, 1};
        vecs[19] = '{0, 0, 0,  24'h000000, 1, 0, 0, 5, 24'h123456, 0, 1, 1};

        apply_reset();
        chk("rst_a_gnt",  32'(a_gnt), 32'(0));
        chk("rst_b_gnt",  32'(b_gnt), 32'(0));
        chk("rst_ram_we", 32'(ram_we), 32'(0));
        chk("rst_addr",   32'(ram_wraddress), 32'(0));
        chk("rst_data",   32'(ram_data), 32'(0));
        chk("rst_ureq",   32'(update_request), 32'(0));
        chk("rst_busy",   32'(busy), 32'(0));
        chk("rst_drop",   32'(drop_err), 32'(0));

        // Table: short A frame, held request through SEND/GAP, out-of-range beat.
        for (int i = 0; i < 20; i++) begin
            a_req = vecs[i].a_req; a_last = vecs[i].a_last;
            a_addr = vecs[i].a_addr; a_data = vecs[i].a_data;
            update_done = vecs[i].update_done;
            tick();
            chk($sformatf("v%0d_a_gnt", i), 32'(a_gnt), 32'(vecs[i].x_a_gnt));
            chk($sformatf("v%0d_b_gnt", i), 32'(b_gnt), 32'(0));
            chk($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].x_ram_we));
            chk($sformatf("v%0d_addr", i), 32'(ram_wraddress), 32'(vecs[i].x_addr));
            chk($sformatf("v%0d_data", i), 32'(ram_data), 32'(exp_color(vecs[i].x_data)));
            chk($sformatf("v%0d_ureq", i), 32'(update_request), 32'(vecs[i].x_ureq));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].x_busy));
            chk($sformatf("v%0d_drop", i), 32'(drop_err), 32'(vecs[i].x_drop));
        end

        // Full 16-LED frame from A, kick latency and gap length.
        apply_reset();
        a_req = 1'b1;
        wait_gnt(1'b0);
        we_count = 0;
        for (int i = 0; i < 16; i++) begin
            a_addr = ADDR_BIT'(i);
            a_data = 24'h00FF00;
            a_last = (i == 15);
            tick();
            if (ram_we === 1'b1) we_count++;
            chk($sformatf("frm%0d_addr", i), 32'(ram_wraddress), 32'(i));
            chk($sformatf("frm%0d_data", i), 32'(ram_data), 32'(exp_color(24'h00FF00)));
        end
        chk("frm_we_count", 32'(we_count), 32'(16));
        chk("frm_gnt_drop", 32'(a_gnt), 32'(0));
        a_req = 1'b0; a_last = 1'b0;
        chk("frm_kick_ureq", 32'(update_request), 32'(0));
        tick();
        chk("frm_send_ureq", 32'(update_request), 32'(1));
        chk("frm_send_we", 32'(ram_we), 32'(0));
        update_done = 1'b1;
        tick();
        update_done = 1'b0;
        chk("frm_gap_ureq", 32'(update_request), 32'(0));
        wait_idle(gap_cycles);
        chk("frm_gap_len", 32'(gap_cycles), 32'(MIN_GAP));

        // Simultaneous requests: A first, then B after A's gap; B drops a beat.
        apply_reset();
        a_req = 1'b1; b_req = 1'b1;
        tick();
        tick();
        chk("rr_first_a", 32'(a_gnt), 32'(1));
        chk("rr_first_b", 32'(b_gnt), 32'(0));
        a_addr = 7; a_data = 24'h0A0B0C; a_last = 1'b1;
        tick();
        chk("rr_a_we", 32'(ram_we), 32'(1));
        chk("rr_a_addr", 32'(ram_wraddress), 32'(7));
        tick();
        update_done = 1'b1;
        tick();
        update_done = 1'b0;
        wait_idle(gap_cycles);
        chk("rr_a_gap", 32'(gap_cycles), 32'(MIN_GAP));
        tick();
        tick();
        chk("rr_then_b", 32'(b_gnt), 32'(1));
        chk("rr_then_a", 32'(a_gnt), 32'(0));
        a_req = 1'b0; a_last = 1'b0;
        b_addr = 16; b_data = 24'hFFFFFF; b_last = 1'b1;
        tick();
        chk("drop_we", 32'(ram_we), 32'(0));
        chk("drop_flag", 32'(drop_err), 32'(1));
        chk("drop_gnt", 32'(b_gnt), 32'(0));
        b_req = 1'b0; b_last = 1'b0;
        tick();
        tick();
        chk("drop_sticky", 32'(drop_err), 32'(1));
        chk("drop_send", 32'(update_request), 32'(1));
        apply_reset();
        chk("drop_cleared", 32'(drop_err), 32'(0));

        // Reset in SEND aborts the handshake.
        a_req = 1'b1;
        wait_gnt(1'b0);
        a_last = 1'b1; a_addr = 2; a_data = 24'h010203;
        tick();
        a_req = 1'b0; a_last = 1'b0;
        tick();
        chk("rs_send_ureq", 32'(update_request), 32'(1));
        reset = 1'b1;
        tick();
        chk("rs_ureq", 32'(update_request), 32'(0));
        chk("rs_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        update_done = 1'b1;
        tick();
        update_done = 1'b0;
        chk("rs_idle_ureq", 32'(update_request), 32'(0));
        chk("rs_idle_busy", 32'(busy), 32'(0));

        // Reset coinciding with an accepted beat suppresses its write.
        a_req = 1'b1;
        wait_gnt(1'b0);
        a_addr = 9; a_data = 24'h445566;
        reset = 1'b1;
        tick();
        chk("rm_we", 32'(ram_we), 32'(0));
        chk("rm_gnt", 32'(a_gnt), 32'(0));
        chk("rm_addr", 32'(ram_wraddress), 32'(0));
        reset = 1'b0;

`ifdef WS2812_BRIGHTNESS_EN
        apply_reset();
        brightness = 8'h80;
        a_req = 1'b1;
        wait_gnt(1'b0);
        a_addr = 1; a_data = 24'hFF40FF; a_last = 1'b1;
        tick();
        chk("bright_data", 32'(ram_data), 32'(24'h7F207F));
        chk("bright_we", 32'(ram_we), 32'(1));
        a_req = 1'b0; a_last = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_frame_scheduler.md
WS2812_FRAME_SCHEDULER -- requirements
Module: ws2812_frame_scheduler

Interface
REQ-001 SHALL have parameter LED_NUM, default 16: number of LEDs in the chain.
REQ-002 SHALL have parameter ADDR_BIT, default $clog2(LED_NUM)+1: colour-RAM address width.
REQ-003 SHALL have parameter MIN_GAP, default 30000: idle clk100 cycles after each frame send (300 us at 100 MHz).
REQ-004 SHALL have port clk100, input, 1: sole clock, 100 MHz.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have ports a_req, a_last, input, 1 each: requester A pixel-write valid; last pixel of frame.
REQ-007 SHALL have ports a_addr, input, ADDR_BIT, and a_data, input, 24: requester A LED index and GRB colour.
REQ-008 SHALL have port a_gnt, output, 1: a beat is accepted when a_req and a_gnt are both 1.
REQ-009 SHALL have requester B ports b_req, b_last, b_addr, b_data and b_gnt, identical in direction, width and meaning to those of A.
REQ-010 SHALL have ports ram_we, output, 1; ram_wraddress, output, ADDR_BIT; ram_data, output, 24: colour-RAM write port, all on clk100.
REQ-011 SHALL have port update_request, output, 1, and port update_done, input, 1: frame-send handshake to the LED driver.
REQ-012 SHALL have port busy, output, 1: high in every state other than IDLE.
REQ-013 SHALL have port drop_err, output, 1: sticky flag for rejected beats.

Function
REQ-014 SHALL implement a state machine with states IDLE, OWN_A, OWN_B, KICK, SEND and GAP.
REQ-015 IDLE: a_req only -> OWN_A; b_req only -> OWN_B; both -> the requester not served last; after reset A has priority.
REQ-016 a_gnt SHALL be 1 only in OWN_A and b_gnt only in OWN_B; grants are registered outputs, so the first beat is accepted one cycle after entering the OWN state.
REQ-017 An accepted beat SHALL drive ram_we=1 with the registered address and data on the next cycle, giving a write latency of 1; otherwise ram_we=0.
REQ-018 A beat with addr >= LED_NUM SHALL be accepted without writing RAM and SHALL set drop_err; drop_err clears only on reset.
REQ-019 Accepting a beat with last=1 SHALL move the FSM to KICK; the grant drops in that same cycle.
REQ-020 KICK SHALL last exactly one cycle, so the final RAM write completes before update_request rises.
REQ-021 update_request SHALL be 1 throughout SEND; SEND -> GAP on the first cycle with update_done=1, and update_request is 0 in GAP.
REQ-022 An update_done pulse arriving outside SEND SHALL be ignored.
REQ-023 GAP SHALL count MIN_GAP cycles, from 0 to MIN_GAP-1, and then move to IDLE; the counter width is $clog2(MIN_GAP+1); no grants are issued during SEND or GAP.
REQ-024 Requests arriving in any non-IDLE state SHALL wait; a requester's req may fall mid-frame, and ownership is kept until its last beat.

Reset
REQ-025 On reset the FSM SHALL be in IDLE and a_gnt, b_gnt, ram_we, update_request, busy and drop_err SHALL all be 0.
REQ-026 On reset ram_wraddress and ram_data SHALL be 0, the GAP counter 0 and round-robin priority set to A.
REQ-027 Reset asserted mid-frame or mid-send SHALL abort the operation without completing any pending write or handshake.

Configuration
REQ-028 With WS2812_BRIGHTNESS_EN defined, the block SHALL add input brightness, 8 bits.
REQ-029 With WS2812_BRIGHTNESS_EN defined, each 8-bit colour channel SHALL be written as (ch*brightness)>>8 in the same write cycle, so latency stays 1.
REQ-030 Without WS2812_BRIGHTNESS_EN defined, the brightness port SHALL be absent and ram_data SHALL equal the accepted data unchanged.

Structure
REQ-031 A shared package ws2812_pkg SHALL hold the FSM state enum, the 24-bit colour typedef and default MIN_GAP.
REQ-032 The sub-module ws2812_rr_arb SHALL implement the 2-way round-robin choice with its last-served register.

Verification
REQ-033 Verify: A writes indices 0..15 of 0x00FF00 with last on index 15 -> 16 ram_we pulses, update_request rises 2 cycles after the final accept, GAP lasts MIN_GAP cycles.
REQ-034 Verify: a_req and b_req rise together in IDLE after reset -> A is served first; after A's GAP, B is granted.
REQ-035 Verify: B beat with addr=16 (LED_NUM=16) -> no ram_we, drop_err=1 until reset.
REQ-036 Verify: a_req held during SEND and GAP -> a_gnt stays 0 until IDLE.
REQ-037 Verify: reset asserted in SEND -> next cycle update_request=0, busy=0, state IDLE.
REQ-038 Verify: with WS2812_BRIGHTNESS_EN defined, brightness=0x80 and data 0xFF40FF -> ram_data=0x7F207F.
